rom_readback: RTL

- Avalon-MM slave that lets the NIOS II read back game ROM contents after programming, byte by byte, to verify the load.
- Sits on the same Avalon bus as the ROM programmer. It drives the ROM read port: address, read strobe, returned byte.
- Contains a prefetch FSM that hides ROM read latency behind AVL_WAITREQUEST.
- Contains an optional bulk checksum engine.

---
 rtl/rom_readback.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/rom_readback.sv
// rom_readback: Avalon-MM slave that lets the CPU read back game ROM contents
// byte by byte. A small prefetch FSM keeps the next byte ready so most DATA
// reads complete without stalling.
// Optional bulk checksum engine: define ROM_RB_CHECKSUM_EN to include it.
`timescale 1ns/1ps
module rom_readback #(
    parameter int ROM_LATENCY = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        AVL_ADDR,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic              AVL_WAITREQUEST,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_RD,
    input  logic [7:0]        FROM_ROM
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READY = 3'd3
`ifdef ROM_RB_CHECKSUM_EN
        , ST_SUM = 3'd4
`endif
    } state_t;

    // Counter value on the cycle the ROM byte is valid (WAIT counts from the
    // cycle after the pulse, SUM counts from the pulse cycle itself).
    localparam logic [2:0] WAIT_LAST = 3'(ROM_LATENCY - 1);
    localparam logic [2:0] SUM_LAST  = 3'(ROM_LATENCY);

    state_t            state_r;
    logic              rom_rd_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [7:0]        data_reg_r;
    logic              data_valid_r;
    logic [15:0]       len_r;
    logic [2:0]        cnt_r;

    logic              busy_s;
    logic [15:0]       sum_s;
    logic              sum_done_s;
    logic [ADDR_W-1:0] rom_addr_s;
    logic [31:0]       readdata_s;
    logic              waitreq_s;
    logic              wr_s;
    logic              addr_wr_s;
    logic              len_wr_s;
    logic              data_acc_s;
    logic              unused_s;

`ifdef ROM_RB_CHECKSUM_EN
    logic              busy_r;
    logic [15:0]       sum_r;
    logic              sum_done_r;
    logic [ADDR_W-1:0] sum_addr_r;
    logic [16:0]       remaining_r;
    logic              start_s;

    assign busy_s     = busy_r;
    assign sum_s      = sum_r;
    assign sum_done_s = sum_done_r;
    assign start_s    = wr_s & (AVL_ADDR == 2'd2) & AVL_WRITEDATA[0];
`else
    assign busy_s     = 1'b0;
    assign sum_s      = 16'h0000;
    assign sum_done_s = 1'b0;
`endif

    // Bus decode; a write in the same cycle as a read suppresses the read.
    assign wr_s       = AVL_CS & AVL_WRITE;
    assign addr_wr_s  = wr_s & (AVL_ADDR == 2'd0);
    assign len_wr_s   = wr_s & (AVL_ADDR == 2'd3);
    assign waitreq_s  = AVL_CS & AVL_READ & (AVL_ADDR == 2'd1) & (~data_valid_r | busy_s);
    assign data_acc_s = AVL_CS & AVL_READ & ~AVL_WRITE & (AVL_ADDR == 2'd1) & ~waitreq_s;
    assign unused_s   = ^AVL_WRITEDATA[31:16];

    assign AVL_WAITREQUEST = waitreq_s;
    assign AVL_READDATA    = readdata_s;
    assign ROM_RD          = rom_rd_r;
    assign ROM_ADDR        = rom_addr_s;

    // ROM address: the checksum walks its own pointer, everything else uses cur_addr.
    always_comb begin
        rom_addr_s = cur_addr_r;
`ifdef ROM_RB_CHECKSUM_EN
        if (state_r == ST_SUM) begin
            rom_addr_s = sum_addr_r;
        end else begin
            rom_addr_s = cur_addr_r;
        end
`endif
    end

    // Register read mux.
    always_comb begin
        readdata_s = 32'h0000_0000;
        case (AVL_ADDR)
            2'd0:    readdata_s = 32'(cur_addr_r);
            2'd1:    readdata_s = {24'h00_0000, data_reg_r};
            2'd2:    readdata_s = {sum_s, 13'h0000, sum_done_s, data_valid_r, busy_s};
            2'd3:    readdata_s = {16'h0000, len_r};
            default: readdata_s = 32'h0000_0000;
        endcase
    end

    // Prefetch / checksum sequencer; ROM_RD is raised on entry to every read slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            rom_rd_r     <= 1'b0;
            cur_addr_r   <= '0;
            data_reg_r   <= 8'h00;
            data_valid_r <= 1'b0;
            len_r        <= 16'h0000;
            cnt_r        <= 3'd0;
`ifdef ROM_RB_CHECKSUM_EN
            busy_r       <= 1'b0;
            sum_r        <= 16'h0000;
            sum_done_r   <= 1'b0;
            sum_addr_r   <= '0;
            remaining_r  <= 17'h0_0000;
`endif
        end else begin
            rom_rd_r <= 1'b0;
            if (len_wr_s) begin
                len_r <= AVL_WRITEDATA[15:0];
            end
            case (state_r)
`ifdef ROM_RB_CHECKSUM_EN
                ST_SUM: begin
                    // cur_addr may be reloaded; its prefetch runs once the sum ends
                    if (addr_wr_s) begin
                        cur_addr_r <= AVL_WRITEDATA[ADDR_W-1:0];
                    end
                    if (cnt_r == SUM_LAST) begin
                        sum_r       <= sum_r + {8'h00, FROM_ROM};
                        sum_addr_r  <= sum_addr_r + ADDR_W'(1);
                        remaining_r <= remaining_r - 17'd1;
                        cnt_r       <= 3'd0;
                        // next checksum slot, or the prefetch FETCH after the last byte
                        rom_rd_r    <= 1'b1;
                        if (remaining_r == 17'd1) begin
                            busy_r     <= 1'b0;
                            sum_done_r <= 1'b1;
                            state_r    <= ST_FETCH;
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
`endif
                default: begin
                    if (addr_wr_s) begin
                        // abort any fetch in flight; its return is never captured
                        cur_addr_r   <= AVL_WRITEDATA[ADDR_W-1:0];
                        data_valid_r <= 1'b0;
                        state_r      <= ST_FETCH;
                        rom_rd_r     <= 1'b1;
                    end
`ifdef ROM_RB_CHECKSUM_EN
                    else if (start_s) begin
                        busy_r       <= 1'b1;
                        sum_r        <= 16'h0000;
                        sum_done_r   <= 1'b0;
                        sum_addr_r   <= cur_addr_r;
                        remaining_r  <= (len_r == 16'h0000) ? 17'h1_0000 : {1'b0, len_r};
                        data_valid_r <= 1'b0;
                        cnt_r        <= 3'd0;
                        state_r      <= ST_SUM;
                        rom_rd_r     <= 1'b1;
                    end
`endif
                    else if (data_acc_s) begin
                        cur_addr_r   <= cur_addr_r + ADDR_W'(1);
                        data_valid_r <= 1'b0;
                        state_r      <= ST_FETCH;
                        rom_rd_r     <= 1'b1;
                    end else begin
                        case (state_r)
                            ST_IDLE: begin
                                state_r  <= ST_FETCH;
                                rom_rd_r <= 1'b1;
                            end
                            ST_FETCH: begin
                                state_r <= ST_WAIT;
                                cnt_r   <= 3'd0;
                            end
                            ST_WAIT: begin
                                if (cnt_r == WAIT_LAST) begin
                                    data_reg_r   <= FROM_ROM;
                                    data_valid_r <= 1'b1;
                                    state_r      <= ST_READY;
                                end else begin
                                    cnt_r <= cnt_r + 3'd1;
                                end
                            end
                            ST_READY: state_r <= ST_READY;
                            default:  state_r <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
